// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the byte-serial arithmetic blocks.
package adder_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/byte_add_unit.sv
// Combinational 8-bit adder exposing the carry into bit 7 so callers can derive
// two's-complement overflow as c7 ^ cout.
module byte_add_unit
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              c7
);

  logic [BYTE_W-1:0] lo;
  logic [1:0]        hi;

  always_comb begin
    lo   = {1'b0, a[BYTE_W-2:0]} + {1'b0, b[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
    c7   = lo[BYTE_W-1];
    hi   = {1'b0, a[BYTE_W-1]} + {1'b0, b[BYTE_W-1]} + {1'b0, c7};
    sum  = {hi[0], lo[BYTE_W-2:0]};
    cout = hi[1];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Byte-serial multi-precision add/subtract sequencer: one byte per cycle, LSB
// first, carry chained through a register, result shifted in from the MSB side.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int CNT_W  = $clog2(NBYTES),
  localparam int W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         carry_in,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BYTE_W-1:0] byte_sum;
  logic              byte_cout;
  logic              byte_c7;
  logic              accept;
  logic              last_byte;

  byte_add_unit u_byte_add (
    .a    (a_q[BYTE_W-1:0]),
    .b    (b_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (byte_sum),
    .cout (byte_cout),
    .c7   (byte_c7)
  );

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign accept    = start && ready;
  assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (accept) begin
      // Subtract is A + ~B + 1, so the inversion happens once at capture.
      state_d  = ST_RUN;
      cnt_d    = '0;
      a_d      = op_a;
      b_d      = sub ? ~op_b : op_b;
      carry_d  = sub ? 1'b1 : carry_in;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (state_q == ST_RUN) begin
      result_d = {byte_sum, result_q[W-1:BYTE_W]};
      carry_d  = byte_cout;
      a_d      = a_q >> BYTE_W;
      b_d      = b_q >> BYTE_W;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_byte) begin
        state_d = ST_DONE;
        cout_d  = byte_cout;
        ovf_d   = byte_c7 ^ byte_cout;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with NBYTES=4: directed operations push
// expected responses, an independent monitor pops and checks on each done pulse.
module tb_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready, busy, done, carry_out, overflow;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .carry_in  (carry_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.r);
        chk("carry_out", W'(carry_out), W'(e.c));
        chk("overflow", W'(overflow), W'(e.o));
        chk("latency", W'(cyc - e.cyc), W'(NB + 1));
      end
    end
  end

  // Called at a negedge; drives start for exactly one edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic ci, input logic [W-1:0] er, input logic ec,
                       input logic eo, input bit expect_done);
    exp_t e;
    chk("ready_before_start", W'(ready), W'(1));
    op_a = a; op_b = b; sub = s; carry_in = ci; start = 1'b1;
    if (expect_done) begin
      e.r = er; e.c = ec; e.o = eo; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    sub = 1'b0; carry_in = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", n);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_cout", W'(carry_out), W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with explicit busy window T+1..T+4.
    issue(32'h000000FE, 32'h00000001, 1'b0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("run_busy", W'(busy), W'(1));
      chk("run_ready", W'(ready), W'(0));
    end
    @(negedge clk);
    chk("done_cycle", W'(done), W'(1));

    // Back-to-back: each start issued in the previous op's done cycle.
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1);
    wait_done();
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    wait_done();
    issue(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    wait_done();
    // carry_in must be ignored on subtract.
    issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b1);
    wait_done();
    issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Idle gap, then check result is held.
    @(negedge clk);
    chk("held_result", result, 32'hACF13568);
    chk("idle_ready", W'(ready), W'(1));

    // Start pulsed mid-RUN with different operands must be ignored.
    issue(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    wait_done();
    @(negedge clk);
    repeat (NB + 2) @(negedge clk);
    chk("no_extra_op", W'(ready), W'(1));

    // Asynchronous reset mid-RUN aborts with no done pulse.
    issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_result", result, '0);
    chk("abort_done", W'(done), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NB + 2) @(negedge clk);
    issue(32'h01000000, 32'h01000000, 1'b0, 1'b0, 32'h02000000, 1'b0, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Byte-serial multi-precision add/subtract sequencer. It drives one shared 8-bit add unit (byte_add_unit) once per cycle, LSB byte first, and chains the carry through a register.
- Captures two NBYTES-wide operands on start and emits the full-width result, carry and signed overflow with a done pulse.
- Sits between a host/register interface and the 8-bit adder datapath, so wide arithmetic needs no wide adder.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 2..16).
- CNT_W, $clog2(NBYTES), width of the byte counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0 = A+B+carry_in, 1 = A-B (carry_in ignored).
- carry_in  in  1  initial carry for add.
- op_a  in  8*NBYTES  operand A, sampled on accepted start.
- op_b  in  8*NBYTES  operand B, sampled on accepted start.
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result is valid from this cycle.
- result  out  8*NBYTES  sum/difference, held until next accepted start.
- carry_out  out  1  final carry (for subtract: 1 = no borrow).
- overflow  out  1  two's-complement overflow of the full-width operation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, carry reg=0, operand regs=0.
  - result=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when counter==NBYTES-1.
  - DONE -> RUN on start, else DONE -> IDLE.
- Accept cycle T (start && ready):
  - latch op_a.
  - latch op_b, or ~op_b when sub=1.
  - carry reg <= sub ? 1 : carry_in.
  - counter <= 0.
  - result, carry_out, overflow cleared to 0.
- Each RUN cycle:
  - byte_add_unit adds the low byte of the A and B shift regs plus the carry reg.
  - The sum byte shifts into result from the MSB side (result <= {sum, result[8*NBYTES-1:8]}).
  - carry reg <= byte carry; A and B regs shift right 8; counter++.
- Last RUN cycle (counter==NBYTES-1):
  - carry_out <= byte carry-out.
  - overflow <= carry into bit 7 XOR carry out of bit 7 of that byte.
- Timing:
  - RUN occupies cycles T+1..T+NBYTES.
  - done=1 in cycle T+NBYTES+1 only.
  - Start-to-done latency is NBYTES+1 cycles.
- Start while busy=1 is ignored; there is no queueing and operands are not re-sampled.
- Start asserted in the DONE cycle is accepted, so ops run back-to-back with 1 idle-free cycle.
- Wrap-around: the result is modulo 2^(8*NBYTES); the excess appears only on carry_out.
- Reset mid-RUN aborts immediately: all outputs return to reset values and no done pulse is issued.
- sub and carry_in are don't-care outside the accept cycle.

Decomposition:
- Shared package (adder_pkg):
  - BYTE_W=8 constant.
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module byte_add_unit: combinational 8-bit a+b+cin producing sum[7:0], cout and c7 (carry into bit 7, for overflow).
  - Instantiated once here.
  - Reused by other datapath blocks.
- The FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
- NBYTES=4: A=0x000000FE, B=0x00000001, carry_in=0, sub=0, start at T -> busy T+1..T+4, done at T+5, result=0x000000FF, carry_out=0, overflow=0.
- A=0xFFFFFFFF, B=0x00000001, carry_in=0 -> result=0x00000000, carry_out=1, overflow=0. Same operands with carry_in=1 -> result=0x00000001, carry_out=1.
- A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, carry_out=0, overflow=1. Then sub=1, A=0x80000000, B=0x00000001 -> result=0x7FFFFFFF, carry_out=1, overflow=1.
- sub=1, A=5, B=7 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
- Start pulsed at T+2 of a running op with different operands -> ignored; the first op's result is unchanged at T+5. Start held in the done cycle -> second done exactly 5 cycles later.
- rst_n low at T+2 mid-RUN -> busy=0, ready=1, result=0 asynchronously, no done pulse. A new op after release completes correctly.
